// File: rtl/coso_beat_sampler.sv
// coso_beat_sampler: gates the COSO ripple counter over one beat period and packs count LSBs into words
module coso_beat_sampler #(
    parameter int width         = 16,
    parameter int outWidth      = 32,
    parameter int settleCycles  = 4,
    parameter int timeoutCycles = 1048576
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                en,
    input  logic                beat,
    input  logic [width-1:0]    cnt,
    output logic                cntClr,
    output logic                cntEn,
    output logic [outWidth-1:0] outData,
    output logic                outValid,
    input  logic                outReady,
    output logic [width-1:0]    lastCnt,
    output logic                errTimeout,
    output logic                errZero,
    output logic                errUnstable
);
    localparam int tw = $clog2(timeoutCycles > 256 ? timeoutCycles : 256);
    localparam int bw = $clog2(outWidth + 1);

    typedef enum logic [2:0] {idle, clear, arm, count, settle, capture, push} state_t;

    state_t state, state_n, rest;
    logic [tw-1:0] tmr;
    logic [bw-1:0] bit_cnt;
    logic [width-1:0] cap_a;
    logic [outWidth-1:0] pack;
    logic s0, s1, s2, rise;
    logic same, tout, acc, zero, unst, load;

    assign rise = s1 & ~s2;

    // beat synchronizer plus one extra stage for rising-edge detection
    always_ff @(posedge clk) begin
        if (clr) {s0, s1, s2} <= 3'b000;
        else {s0, s1, s2} <= {beat, s0, s1};
    end

    // next state and per-cycle events; compares are made against the live count so a stable capture takes two cycles
    always_comb begin
        rest = en ? clear : idle;
        same = cap_a == cnt;
        tout = (state == arm || state == count) && tmr == tw'(timeoutCycles - 1);
        unst = state == capture && tmr == tw'(4) && !same;
        zero = state == capture && tmr != '0 && same && cnt == '0;
        acc = state == capture && tmr != '0 && same && cnt != '0;
        load = state == push && (!outValid || outReady);
        state_n = state;
        case (state)
            idle:    state_n = en ? clear : idle;
            clear:   state_n = tmr == tw'(1) ? arm : clear;
            arm:     state_n = tout ? rest : rise ? count : arm;
            count:   state_n = tout ? rest : rise ? settle : count;
            settle:  state_n = tmr == tw'(settleCycles - 1) ? capture : settle;
            capture: state_n = acc && bit_cnt == bw'(outWidth - 1) ? push : (acc || zero || unst) ? rest : capture;
            push:    state_n = load ? rest : push;
            default: state_n = idle;
        endcase
    end

    // state register, per-state cycle timer and registered counter controls derived from the next state
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= idle;
            tmr <= '0;
            cntClr <= 1'b1;
            cntEn <= 1'b0;
        end else begin
            state <= state_n;
            tmr <= state_n != state ? '0 : tmr + 1'b1;
            cntClr <= state_n == idle || state_n == clear || state_n == push;
            cntEn <= state_n == count;
        end
    end

    // capture, bit packing, output handshake and sticky error flags
    always_ff @(posedge clk) begin
        if (clr) begin
            cap_a <= '0;
            pack <= '0;
            bit_cnt <= '0;
            outData <= '0;
            outValid <= 1'b0;
            lastCnt <= '0;
            errTimeout <= 1'b0;
            errZero <= 1'b0;
            errUnstable <= 1'b0;
        end else begin
            if (state == capture) cap_a <= cnt;
            if (acc) begin
                lastCnt <= cnt;
                pack <= (bit_cnt == '0 ? '0 : pack) | (outWidth'(cnt[0]) << bit_cnt);
            end
            bit_cnt <= load ? '0 : acc ? bit_cnt + 1'b1 : bit_cnt;
            if (load) outData <= pack;
            outValid <= load | (outValid & ~outReady);
            errTimeout <= errTimeout | tout;
            errZero <= errZero | zero;
            errUnstable <= errUnstable | unst;
        end
    end
endmodule

// File: tb/tb_coso_beat_sampler.sv
// tb_coso_beat_sampler: directed scenario bench for the beat sampler
module tb_coso_beat_sampler;
    logic clk = 1'b0, clr = 1'b1, en = 1'b0, beat, outReady = 1'b1;
    logic [15:0] cnt = 16'h0000;
    logic cntClr, cntEn, outValid, errTimeout, errZero, errUnstable;
    logic [7:0] outData;
    logic [15:0] lastCnt;
    int tests = 0, fails = 0;
    bit beat_on = 1'b1, spin = 1'b0;
    int beat_ph = 0;
    logic [7:0] w3 = 8'h9D;

    coso_beat_sampler #(.width(16), .outWidth(8), .settleCycles(4), .timeoutCycles(64)) dut (
        .clk(clk), .clr(clr), .en(en), .beat(beat), .cnt(cnt),
        .cntClr(cntClr), .cntEn(cntEn), .outData(outData), .outValid(outValid),
        .outReady(outReady), .lastCnt(lastCnt), .errTimeout(errTimeout),
        .errZero(errZero), .errUnstable(errUnstable)
    );

    always #5 clk = ~clk;

    initial begin
        beat = 1'b0;
        forever begin
            @(negedge clk);
            if (beat_on) begin
                beat_ph = beat_ph + 1;
                if (beat_ph >= 20) begin
                    beat = ~beat;
                    beat_ph = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (spin) cnt = cnt + 16'd1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_sample(input logic [15:0] v, input bit last, output int hi, output bit ok);
        int n;
        cnt = v;
        ok = 1'b1;
        hi = 0;
        n = 0;
        while (cntEn !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (cntEn !== 1'b1) ok = 1'b0;
        if (last) en = 1'b0;
        while (cntEn === 1'b1 && hi < 300) begin
            @(negedge clk);
            hi++;
        end
        if (cntEn === 1'b1) ok = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset;
        clr = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({cntClr, cntEn, outValid, errTimeout, errZero, errUnstable} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_flags: got %b want 100000", {cntClr, cntEn, outValid, errTimeout, errZero, errUnstable});
        end
        tests++;
        if (outData !== 8'h00) begin
            fails++;
            $display("FAIL reset_outdata: got %h want 00", outData);
        end
        tests++;
        if (lastCnt !== 16'h0000) begin
            fails++;
            $display("FAIL reset_lastcnt: got %h want 0000", lastCnt);
        end
        clr = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if ({cntClr, cntEn} !== 2'b10) begin
            fails++;
            $display("FAIL idle_hold: got %b want 10", {cntClr, cntEn});
        end
    endtask

    task automatic test_nominal;
        logic [15:0] v;
        int hi;
        bit ok;
        en = 1'b1;
        outReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = i[0] ? 16'h00A4 : 16'h00A5;
            do_sample(v, i == 7, hi, ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL nominal_wait: sample %0d cntEn edge missing", i);
            end
            tests++;
            if (hi < 39 || hi > 41) begin
                fails++;
                $display("FAIL nominal_en_width: got %0d cycles want 40", hi);
            end
            tests++;
            if (lastCnt !== v) begin
                fails++;
                $display("FAIL nominal_lastcnt: got %h want %h", lastCnt, v);
            end
        end
        @(negedge clk);
        tests++;
        if ({outValid, outData} !== {1'b1, 8'h55}) begin
            fails++;
            $display("FAIL nominal_word: got %b/%h want 1/55", outValid, outData);
        end
        @(negedge clk);
        tests++;
        if (outValid !== 1'b0) begin
            fails++;
            $display("FAIL nominal_valid_pulse: got %b want 0", outValid);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] w1, w2;
        logic b;
        int hi;
        bit ok;
        w1 = 8'hC3;
        w2 = 8'h3C;
        en = 1'b1;
        outReady = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b = i < 8 ? w1[i] : w2[i-8];
            do_sample({15'h0900, b}, i == 15, hi, ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL bp_wait: sample %0d cntEn edge missing", i);
            end
            if (i == 7) begin
                @(negedge clk);
                tests++;
                if ({outValid, outData} !== {1'b1, 8'hC3}) begin
                    fails++;
                    $display("FAIL bp_first_word: got %b/%h want 1/c3", outValid, outData);
                end
            end
            if (i > 7 && i < 15) begin
                tests++;
                if ({outValid, outData} !== {1'b1, 8'hC3}) begin
                    fails++;
                    $display("FAIL bp_hold: got %b/%h want 1/c3", outValid, outData);
                end
            end
        end
        repeat (3) begin
            tests++;
            if ({cntClr, cntEn, outValid, outData} !== {3'b101, 8'hC3}) begin
                fails++;
                $display("FAIL bp_stall: got %b/%h want 101/c3", {cntClr, cntEn, outValid}, outData);
            end
            @(negedge clk);
        end
        outReady = 1'b1;
        @(negedge clk);
        tests++;
        if ({outValid, outData} !== {1'b1, 8'h3C}) begin
            fails++;
            $display("FAIL bp_second_word: got %b/%h want 1/3c", outValid, outData);
        end
        @(negedge clk);
        tests++;
        if (outValid !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain: got %b want 0", outValid);
        end
    endtask

    task automatic test_timeout;
        int hi, n;
        bit ok;
        en = 1'b1;
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_sample({15'h0900, w3[i]}, 1'b0, hi, ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL to_pre_wait: sample %0d cntEn edge missing", i);
            end
        end
        n = 0;
        while (cntEn !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (cntEn !== 1'b1) begin
            fails++;
            $display("FAIL to_count_entry: got cntEn %b want 1", cntEn);
        end
        beat_on = 1'b0;
        repeat (63) @(negedge clk);
        tests++;
        if ({cntEn, errTimeout} !== 2'b10) begin
            fails++;
            $display("FAIL to_early: got %b want 10", {cntEn, errTimeout});
        end
        @(negedge clk);
        tests++;
        if ({errTimeout, cntEn, cntClr} !== 3'b101) begin
            fails++;
            $display("FAIL to_abort: got %b want 101", {errTimeout, cntEn, cntClr});
        end
        tests++;
        if (lastCnt !== 16'h1201) begin
            fails++;
            $display("FAIL to_lastcnt: got %h want 1201", lastCnt);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (cntClr !== 1'b0) begin
            fails++;
            $display("FAIL to_rearm: got cntClr %b want 0", cntClr);
        end
        beat_on = 1'b1;
        for (int i = 3; i < 5; i++) begin
            do_sample({15'h0900, w3[i]}, 1'b0, hi, ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL to_post_wait: sample %0d cntEn edge missing", i);
            end
        end
    endtask

    task automatic test_zero;
        int hi;
        bit ok;
        do_sample(16'h0000, 1'b0, hi, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL zero_wait: cntEn edge missing");
        end
        tests++;
        if ({errZero, errUnstable} !== 2'b10) begin
            fails++;
            $display("FAIL zero_flag: got %b want 10", {errZero, errUnstable});
        end
        tests++;
        if (lastCnt !== 16'h1201) begin
            fails++;
            $display("FAIL zero_lastcnt: got %h want 1201", lastCnt);
        end
    endtask

    task automatic test_unstable;
        int hi;
        bit ok;
        spin = 1'b1;
        do_sample(16'h0100, 1'b0, hi, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL unst_wait: cntEn edge missing");
        end
        repeat (2) @(negedge clk);
        tests++;
        if (errUnstable !== 1'b0) begin
            fails++;
            $display("FAIL unst_early: got %b want 0", errUnstable);
        end
        @(negedge clk);
        tests++;
        if (errUnstable !== 1'b1) begin
            fails++;
            $display("FAIL unst_flag: got %b want 1", errUnstable);
        end
        tests++;
        if (lastCnt !== 16'h1201) begin
            fails++;
            $display("FAIL unst_lastcnt: got %h want 1201", lastCnt);
        end
        spin = 1'b0;
    endtask

    task automatic test_word_after_errors;
        int hi;
        bit ok;
        for (int i = 5; i < 8; i++) begin
            do_sample({15'h0900, w3[i]}, i == 7, hi, ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL err_word_wait: sample %0d cntEn edge missing", i);
            end
        end
        @(negedge clk);
        tests++;
        if ({outValid, outData} !== {1'b1, 8'h9D}) begin
            fails++;
            $display("FAIL err_word: got %b/%h want 1/9d", outValid, outData);
        end
    endtask

    task automatic test_reset_mid_count;
        logic [7:0] w4;
        int hi, n;
        bit ok;
        w4 = 8'h5A;
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            do_sample(16'h1201, 1'b0, hi, ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL mid_pre_wait: sample %0d cntEn edge missing", i);
            end
        end
        n = 0;
        while (cntEn !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (cntEn !== 1'b1) begin
            fails++;
            $display("FAIL mid_count_entry: got cntEn %b want 1", cntEn);
        end
        clr = 1'b1;
        @(negedge clk);
        tests++;
        if ({cntClr, cntEn, outValid, errTimeout, errZero, errUnstable} !== 6'b100000) begin
            fails++;
            $display("FAIL mid_flags: got %b want 100000", {cntClr, cntEn, outValid, errTimeout, errZero, errUnstable});
        end
        tests++;
        if ({outData, lastCnt} !== 24'h000000) begin
            fails++;
            $display("FAIL mid_data: got %h/%h want 00/0000", outData, lastCnt);
        end
        clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_sample({15'h0900, w4[i]}, i == 7, hi, ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL mid_post_wait: sample %0d cntEn edge missing", i);
            end
        end
        @(negedge clk);
        tests++;
        if ({outValid, outData} !== {1'b1, 8'h5A}) begin
            fails++;
            $display("FAIL mid_word: got %b/%h want 1/5a", outValid, outData);
        end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_backpressure;
        test_timeout;
        test_zero;
        test_unstable;
        test_word_after_errors;
        test_reset_mid_count;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
